// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity encodings and the
// baud divider helper used by both the transmit and receive paths.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Clock cycles per bit period, integer-truncated.
    function automatic int baud_div(input int clk_freq, input int bdr);
        return clk_freq / bdr;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO feeding the UART transmitter. Head word is
// presented combinationally on dout; a push while full is dropped unless
// a pop frees a slot on the same edge.
module uart_tx_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage array write port.
    // NOTE: the data array has no reset; only pointers and level define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo_sender.sv
// UART transmitter with input FIFO: start bit, LSB-first data, optional
// parity, 1 or 2 stop bits. txd is registered, so the start bit appears two
// edges after a push into an empty FIFO. Back-to-back frames have no gap.
// Optional build macro UART_TX_BREAK_EN adds break_req, which holds the idle
// line low once the current frame has finished.
module uart_tx_fifo_sender
    import uart_pkg::*;
#(
    parameter int EIGHT_BIT_DATA = 8,
    parameter int PARITY_BIT     = 0,
    parameter int STOP_BIT       = 2,
    parameter int DEFAULT_BDR    = 115200,
    parameter int CLK_FREQ       = 50000000,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [EIGHT_BIT_DATA-1:0]     wr_data,
`ifdef UART_TX_BREAK_EN
    input  logic                          break_req,
`endif
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          txd,
    output logic                          busy
);

    localparam int       BAUD_DIV  = baud_div(CLK_FREQ, DEFAULT_BDR);
    localparam int       BW        = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [2:0]    LAST_DATA = 3'(EIGHT_BIT_DATA - 1);
    localparam logic [2:0]    LAST_STOP = 3'(STOP_BIT - 1);

    uart_state_t                state;
    uart_state_t                state_next;
    logic [EIGHT_BIT_DATA-1:0]  shift;
    logic [EIGHT_BIT_DATA-1:0]  fifo_dout;
    logic [BW-1:0]              baud_cnt;
    logic [2:0]                 bit_cnt;
    logic                       par_bit;
    logic                       fifo_empty;
    logic                       brk;
    logic                       pop;
    logic                       bit_end;
    logic                       bit_clr;
    logic                       bit_inc;
    logic                       shift_en;
    logic                       txd_next;

`ifdef UART_TX_BREAK_EN
    assign brk = break_req;
`else
    assign brk = 1'b0;
`endif

    uart_tx_fifo #(
        .WIDTH (EIGHT_BIT_DATA),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (wr_en),
        .pop   (pop),
        .din   (wr_data),
        .dout  (fifo_dout),
        .level (fifo_level),
        .full  (full),
        .empty (fifo_empty)
    );

    assign bit_end = (state != IDLE) && (baud_cnt == BAUD_LAST);
    assign busy    = (state != IDLE) || (fifo_level != '0) || brk;

    // FSM state register.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state, FIFO pop and line value for the next cycle.
    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        txd_next   = 1'b1;
        bit_clr    = 1'b0;
        bit_inc    = 1'b0;
        shift_en   = 1'b0;
        case (state)
            IDLE: begin
                if (brk) begin
                    txd_next = 1'b0;
                end else if (!fifo_empty) begin
                    pop        = 1'b1;
                    bit_clr    = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                txd_next = 1'b0;
                if (bit_end) state_next = DATA;
            end
            DATA: begin
                txd_next = shift[0];
                if (bit_end) begin
                    shift_en = 1'b1;
                    if (bit_cnt == LAST_DATA) begin
                        bit_clr = 1'b1;
                        if (PARITY_BIT != PAR_NONE) state_next = PARITY;
                        else                        state_next = STOP;
                    end else begin
                        bit_inc = 1'b1;
                    end
                end
            end
            PARITY: begin
                txd_next = par_bit;
                if (bit_end) state_next = STOP;
            end
            STOP: begin
                txd_next = 1'b1;
                if (bit_end) begin
                    if (bit_cnt == LAST_STOP) begin
                        bit_clr = 1'b1;
                        if (!fifo_empty && !brk) begin
                            pop        = 1'b1;
                            state_next = START;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        bit_inc = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: registered line, shift register, parity, bit and baud counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            txd      <= 1'b1;
            shift    <= '0;
            par_bit  <= 1'b0;
            bit_cnt  <= '0;
            baud_cnt <= '0;
        end else begin
            txd <= txd_next;
            if (pop) begin
                shift   <= fifo_dout;
                par_bit <= (^fifo_dout) ^ (PARITY_BIT == PAR_ODD);
            end else if (shift_en) begin
                shift <= shift >> 1;
            end
            if (bit_clr)      bit_cnt <= '0;
            else if (bit_inc) bit_cnt <= bit_cnt + 1'b1;
            if (state == IDLE || bit_end) baud_cnt <= '0;
            else                          baud_cnt <= baud_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_sender.sv
// Bench for uart_tx_fifo_sender: four instances (8N2 at default baud, 8N2
// fast, 8E1 fast, 8O1 fast) share clock, reset and wr_data. A serial
// receiver model decodes the selected txd and scores bytes against a queue
// of accepted pushes.
module tb_uart_tx_fifo_sender;

    localparam int FAST_CLK = 1000000;
    localparam int FAST_BDR = 100000;
    localparam int FAST_DIV = 10;
    localparam int SLOW_DIV = 434;
    localparam int RX_LIMIT = 20000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  wr_data;
    logic [3:0]  wr_en_v;
    logic        break_req;
    logic [3:0]  txd_v;
    logic [3:0]  busy_v;
    logic [3:0]  full_v;
    logic [4:0]  lvl_v [4];
    logic        mon_txd;
    int          sel = 0;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  sb_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign mon_txd = txd_v[sel[1:0]];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        uart_tx_fifo_sender #(
            .EIGHT_BIT_DATA (8),
            .PARITY_BIT     (g == 2 ? 2 : (g == 3 ? 1 : 0)),
            .STOP_BIT       (g >= 2 ? 1 : 2),
            .DEFAULT_BDR    (g == 0 ? 115200 : FAST_BDR),
            .CLK_FREQ       (g == 0 ? 50000000 : FAST_CLK),
            .FIFO_DEPTH     (16)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .wr_en      (wr_en_v[g]),
            .wr_data    (wr_data),
`ifdef UART_TX_BREAK_EN
            .break_req  (g == 1 ? break_req : 1'b0),
`endif
            .full       (full_v[g]),
            .fifo_level (lvl_v[g]),
            .txd        (txd_v[g]),
            .busy       (busy_v[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; the push lands on the following posedge.
    task automatic push(input int which, input logic [7:0] d, input bit accept);
        wr_en_v[which] = 1'b1;
        wr_data        = d;
        @(negedge clk);
        wr_en_v[which] = 1'b0;
        if (accept) sb_q.push_back(d);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic rx_frame(input int div, input int par, input int nstop,
                            output logic [7:0] data, output logic pbit,
                            output int start_c, output bit got);
        int n;
        got = 1'b0; data = '0; pbit = 1'b0; start_c = 0; n = 0;
        @(negedge clk);
        while (mon_txd !== 1'b1 && n < RX_LIMIT) begin @(negedge clk); n++; end
        while (mon_txd !== 1'b0 && n < RX_LIMIT) begin @(negedge clk); n++; end
        if (n >= RX_LIMIT) begin
            check("rx_timeout", 1, 0);
            return;
        end
        start_c = cyc;
        repeat (div / 2) @(negedge clk);
        check("start_bit", mon_txd, 0);
        for (int k = 0; k < 8; k++) begin
            repeat (div) @(negedge clk);
            data[k] = mon_txd;
        end
        if (par != 0) begin
            repeat (div) @(negedge clk);
            pbit = mon_txd;
        end
        for (int s = 0; s < nstop; s++) begin
            repeat (div) @(negedge clk);
            check("stop_bit", mon_txd, 1);
        end
        got = 1'b1;
    endtask

    task automatic rx_score(input string tag, input int div, input int par, input int nstop,
                            output int start_c, output bit got);
        logic [7:0] d;
        logic [7:0] e;
        logic       p;
        rx_frame(div, par, nstop, d, p, start_c, got);
        if (!got) return;
        if (sb_q.size() == 0) begin
            check({tag, "_unexpected_frame"}, 1, 0);
            return;
        end
        e = sb_q.pop_front();
        check(tag, d, e);
        if (par != 0) check({tag, "_parity"}, p, (^e) ^ (par == 1));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int  sc;
        int  e0;
        int  push_c;
        bit  got;
        bit  bad;
        rst_n = 1'b0; wr_en_v = '0; wr_data = '0; break_req = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_txd", txd_v, 4'hf);
        check("rst_busy", busy_v, 4'h0);
        check("rst_full", full_v, 4'h0);
        check("rst_level", lvl_v[0], 0);
        rst_n = 1'b1;

        // Long idle period: line stays high, nothing reported busy.
        bad = 1'b0;
        repeat (10000) begin
            @(negedge clk);
            if (txd_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || lvl_v[0] !== 5'd0) bad = 1'b1;
        end
        check("idle_quiet", bad, 0);

        // Single 0xA5 frame at default 8N2 / 434 cycles per bit.
        sel = 0;
        push(0, 8'hA5, 1);
        push_c = cyc;
        check("a5_level", lvl_v[0], 1);
        check("a5_busy", busy_v[0], 1);
        rx_score("a5_data", SLOW_DIV, 0, 2, sc, got);
        check("a5_latency", sc - push_c, 2);
        wait_cyc(sc + 11 * SLOW_DIV - 2);
        check("a5_busy_late", busy_v[0], 1);
        wait_cyc(sc + 11 * SLOW_DIV);
        check("a5_busy_done", busy_v[0], 0);
        check("a5_txd_idle", txd_v[0], 1);

        // Burst of 17 bytes, a dropped push while full, and a push on a pop edge.
        sel = 1;
        fork
            begin
                push(1, 8'h00, 1);
                e0 = cyc;
                for (int i = 1; i <= 16; i++) push(1, 8'(i), 1);
                check("burst_full", full_v[1], 1);
                check("burst_level", lvl_v[1], 16);
                push(1, 8'hEE, 0);
                check("drop_level", lvl_v[1], 16);
                wait_cyc(e0 + 11 * FAST_DIV);
                push(1, 8'h11, 1);
                check("pushpop_level", lvl_v[1], 16);
                check("pushpop_full", full_v[1], 1);
            end
            begin
                int prev;
                prev = 0;
                for (int i = 0; i < 18; i++) begin
                    rx_score("burst_data", FAST_DIV, 0, 2, sc, got);
                    if (!got) break;
                    if (i > 0) check("burst_gap", sc - prev, 11 * FAST_DIV);
                    prev = sc;
                end
            end
        join
        wait_cyc(cyc + 3 * FAST_DIV);
        check("burst_idle_busy", busy_v[1], 0);
        check("burst_sb_empty", sb_q.size(), 0);

        // Reset during data bit 3 of the first of three queued frames.
        push(1, 8'h00, 1);
        push(1, 8'h11, 1);
        push(1, 8'h22, 1);
        bad = 1'b1;
        for (int n = 0; n < 100; n++) begin
            if (mon_txd === 1'b0) begin bad = 1'b0; break; end
            @(negedge clk);
        end
        check("rst_mid_start_seen", bad, 0);
        repeat (4 * FAST_DIV + FAST_DIV / 2) @(negedge clk);
        check("rst_mid_pre_txd", mon_txd, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_txd", txd_v[1], 1);
        check("rst_mid_level", lvl_v[1], 0);
        check("rst_mid_busy", busy_v[1], 0);
        rst_n = 1'b1;
        sb_q.delete();
        bad = 1'b0;
        repeat (500) begin
            @(negedge clk);
            if (txd_v[1] !== 1'b1) bad = 1'b1;
        end
        check("rst_mid_no_frames", bad, 0);

        // Parity: even (instance 2) and odd (instance 3), 1 stop bit.
        sel = 2;
        push(2, 8'h07, 1);
        rx_score("even_07", FAST_DIV, 2, 1, sc, got);
        push(2, 8'h3C, 1);
        rx_score("even_3c", FAST_DIV, 2, 1, sc, got);
        sel = 3;
        push(3, 8'h07, 1);
        rx_score("odd_07", FAST_DIV, 1, 1, sc, got);
        push(3, 8'h3C, 1);
        rx_score("odd_3c", FAST_DIV, 1, 1, sc, got);

`ifdef UART_TX_BREAK_EN
        // Break raised mid-frame: frame completes, line held low, queued byte follows release.
        sel = 1;
        push(1, 8'h5A, 1);
        fork
            rx_score("brk_frame", FAST_DIV, 0, 2, sc, got);
            begin
                wait_cyc(cyc + 30);
                break_req = 1'b1;
            end
        join
        wait_cyc(cyc + 2 * FAST_DIV);
        push(1, 8'hC3, 1);
        wait_cyc(cyc + 30);
        check("brk_txd_low", txd_v[1], 0);
        check("brk_busy", busy_v[1], 1);
        check("brk_level", lvl_v[1], 1);
        break_req = 1'b0;
        rx_score("brk_after", FAST_DIV, 0, 2, sc, got);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
